// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//
// Drains words from the pop side of a FiFo and sends each one as a 1-bit
// valid/ready stream. It sits between a FiFo and any bit-serial sink.
//
// Optional build macro: FIFO_READER_PARITY_EN
//   defined     : an even-parity bit (XOR of the data bits) follows every
//                 word. io_out_last marks the parity bit. NBITS = WIDTH+1.
//   not defined : data bits only. io_out_last marks the final data bit.
//                 NBITS = WIDTH.
//
// Parameters
//   WIDTH      FiFo word width (>= 1)
//   MSB_FIRST  1: bit WIDTH-1 goes first; 0: bit 0 goes first
//   CNT_W      width of the words-sent counter
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low (0 = in reset)
//   io_fifo_dout   in   FiFo head word; valid whenever io_fifo_empty = 0
//   io_fifo_empty  in   FiFo empty flag
//   io_fifo_pop    out  pop request; the pop takes effect at the next edge
//   io_out_valid   out  serial bit valid
//   io_out_ready   in   sink ready
//   io_out_data    out  serial bit
//   io_out_last    out  high on the final bit of the current word
//   io_words_sent  out  completed words, wraps modulo 2^CNT_W
//   io_busy        out  FSM state: 1 while a word is held (SHIFT)
//
// Handshake: a bit moves on every rising edge where io_out_valid and
// io_out_ready are both 1. While io_out_valid = 1 and io_out_ready = 0,
// io_out_data, io_out_last and all internal state hold; valid never drops
// until the bit is taken.

module fifo_stream_reader #(
    parameter int WIDTH     = 2,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] io_fifo_dout,
    input  logic             io_fifo_empty,
    output logic             io_fifo_pop,
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic             io_out_data,
    output logic             io_out_last,
    output logic [CNT_W-1:0] io_words_sent,
    output logic             io_busy
);

`ifdef FIFO_READER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam int              BC_W    = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(NBITS - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] load_word;
    logic [BC_W-1:0]  bitcnt;
    logic [CNT_W-1:0] words_sent;

    logic busy;
    logic at_last;
    logic accept;
    logic head_bit;

    // The parity bit is placed so that it leaves after the data bits in
    // either shift direction.
    always_comb begin
        load_word = '0;
`ifdef FIFO_READER_PARITY_EN
        if (MSB_FIRST != 0) begin
            load_word = {io_fifo_dout, ^io_fifo_dout};
        end else begin
            load_word = {^io_fifo_dout, io_fifo_dout};
        end
`else
        load_word = io_fifo_dout;
`endif
    end

    always_comb begin
        head_bit = (MSB_FIRST != 0) ? shreg[NBITS-1] : shreg[0];
    end

    assign busy    = (state == S_SHIFT);
    assign at_last = (bitcnt == '0);
    assign accept  = busy & io_out_ready;

    // Pop in IDLE whenever a word is present, or on the final bit of a word
    // so the next word starts with no bubble. Gated by reset so no pop can
    // leak out while the block is held in reset.
    assign io_fifo_pop = reset & ~io_fifo_empty & (~busy | (accept & at_last));

    assign io_out_valid  = busy;
    assign io_out_data   = busy & head_bit;
    assign io_out_last   = busy & at_last;
    assign io_words_sent = words_sent;
    assign io_busy       = busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bitcnt     <= '0;
            words_sent <= '0;
        end else begin
            if (io_fifo_pop) begin
                // dout is captured only here; later changes do not matter
                shreg  <= load_word;
                bitcnt <= BC_LAST;
                state  <= S_SHIFT;
            end else if (accept) begin
                if (at_last) begin
                    state <= S_IDLE;
                end else begin
                    if (MSB_FIRST != 0) begin
                        shreg <= shreg << 1;
                    end else begin
                        shreg <= shreg >> 1;
                    end
                    bitcnt <= bitcnt - BC_W'(1);
                end
            end

            if (accept && at_last) begin
                words_sent <= words_sent + CNT_W'(1);
            end
        end
    end

endmodule
